// File: rtl/vga_pkg.sv
// vga_pkg: shared raster timing constants, the coordinate type and the sync-window decode
// helpers. Defaults describe 640x480 @ 60 Hz with a 50 MHz clock divided by two.
package vga_pkg;

  localparam int unsigned CoordW   = 10;
  localparam int unsigned MaxTotal = 1 << CoordW;

  localparam int unsigned DefHVisible = 640;
  localparam int unsigned DefHFront   = 16;
  localparam int unsigned DefHSync    = 96;
  localparam int unsigned DefHBack    = 48;
  localparam int unsigned DefVVisible = 480;
  localparam int unsigned DefVFront   = 10;
  localparam int unsigned DefVSync    = 2;
  localparam int unsigned DefVBack    = 33;
  localparam int unsigned DefClkDiv   = 2;

  localparam int unsigned DefHTotal = DefHVisible + DefHFront + DefHSync + DefHBack;
  localparam int unsigned DefVTotal = DefVVisible + DefVFront + DefVSync + DefVBack;

  typedef logic [CoordW-1:0] coord_t;

  // True when lo <= v < lo + len.
  function automatic logic in_window(coord_t v, int unsigned lo, int unsigned len);
    int unsigned vv;
    vv = 32'(v);
    return (vv >= lo) && (vv < lo + len);
  endfunction

  // Active-low sync level for a coordinate: low inside the pulse that follows the front porch.
  function automatic logic sync_level(coord_t v, int unsigned visible, int unsigned front,
                                      int unsigned width);
    return ~in_window(v, visible + front, width);
  endfunction

endpackage

// File: rtl/vga_wrap_counter.sv
// vga_wrap_counter: counts 0..MAX while En is high and wraps to 0.
// Ports:
//   Clk, Reset - clock, asynchronous active-high reset
//   En         - advance enable
//   Count      - current count (the register itself)
//   Wrap       - combinational, high when En is set and Count == MAX
module vga_wrap_counter #(
  parameter int unsigned MAX = 1,
  parameter int unsigned W   = 1
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         En,
  output logic [W-1:0] Count,
  output logic         Wrap
);

  localparam logic [W-1:0] MaxC = W'(MAX);

  assign Wrap = En && (Count == MaxC);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Count <= '0;
    end else if (Wrap) begin
      Count <= '0;
    end else if (En) begin
      Count <= Count + W'(1);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing generator for the VGA display path.
// Ports:
//   Clk, Reset     - system clock, asynchronous active-high reset
//   PixelEn        - one-Clk strobe on which the raster advances
//   DrawX, DrawY   - current column / row (the counter registers)
//   Blank          - 1 on visible pixels, 0 in blanking
//   hs, vs         - active-low horizontal / vertical sync
//   Sync           - composite sync, tied low
//   LineStart      - one-Clk pulse on entry to DrawX = 0
//   FrameStart     - one-Clk pulse on entry to (0,0) after a frame wrap
//   VBlankStart    - one-Clk pulse on entry to (0,V_VISIBLE)
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_VISIBLE = DefHVisible,
  parameter int unsigned H_FRONT   = DefHFront,
  parameter int unsigned H_SYNC    = DefHSync,
  parameter int unsigned H_BACK    = DefHBack,
  parameter int unsigned V_VISIBLE = DefVVisible,
  parameter int unsigned V_FRONT   = DefVFront,
  parameter int unsigned V_SYNC    = DefVSync,
  parameter int unsigned V_BACK    = DefVBack,
  parameter int unsigned CLK_DIV   = DefClkDiv
) (
  input  logic   Clk,
  input  logic   Reset,
  output logic   PixelEn,
  output coord_t DrawX,
  output coord_t DrawY,
  output logic   Blank,
  output logic   hs,
  output logic   vs,
  output logic   Sync,
  output logic   LineStart,
  output logic   FrameStart,
  output logic   VBlankStart
);

  localparam int unsigned HTotal = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned VTotal = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned DivW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam coord_t HVisC     = coord_t'(H_VISIBLE);
  localparam coord_t VVisC     = coord_t'(V_VISIBLE);
  localparam coord_t VLastVisC = coord_t'(V_VISIBLE - 1);

  if (HTotal > MaxTotal || VTotal > MaxTotal || CLK_DIV < 1) begin : g_bad_params
    $error("vga_timing_gen: totals must be <= 1024 and CLK_DIV >= 1");
  end

  logic [DivW-1:0] div;
  logic            h_wrap;
  logic            v_wrap;
  coord_t          x_next;
  coord_t          y_next;

  // Divider always runs, so its wrap is exactly div == CLK_DIV-1.
  vga_wrap_counter #(
    .MAX (CLK_DIV - 1),
    .W   (DivW)
  ) u_div (
    .Clk   (Clk),
    .Reset (Reset),
    .En    (1'b1),
    .Count (div),
    .Wrap  (PixelEn)
  );

  vga_wrap_counter #(
    .MAX (HTotal - 1),
    .W   (CoordW)
  ) u_h (
    .Clk   (Clk),
    .Reset (Reset),
    .En    (PixelEn),
    .Count (DrawX),
    .Wrap  (h_wrap)
  );

  vga_wrap_counter #(
    .MAX (VTotal - 1),
    .W   (CoordW)
  ) u_v (
    .Clk   (Clk),
    .Reset (Reset),
    .En    (h_wrap),
    .Count (DrawY),
    .Wrap  (v_wrap)
  );

  // Next counter values, so the registered flags line up with the counters they describe.
  always_comb begin
    x_next = DrawX;
    y_next = DrawY;
    if (h_wrap) begin
      x_next = '0;
    end else if (PixelEn) begin
      x_next = DrawX + coord_t'(1);
    end
    if (v_wrap) begin
      y_next = '0;
    end else if (h_wrap) begin
      y_next = DrawY + coord_t'(1);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Blank       <= 1'b1;
      hs          <= 1'b1;
      vs          <= 1'b1;
      LineStart   <= 1'b0;
      FrameStart  <= 1'b0;
      VBlankStart <= 1'b0;
    end else begin
      Blank       <= (x_next < HVisC) && (y_next < VVisC);
      hs          <= sync_level(x_next, H_VISIBLE, H_FRONT, H_SYNC);
      vs          <= sync_level(y_next, V_VISIBLE, V_FRONT, V_SYNC);
      LineStart   <= h_wrap;
      FrameStart  <= h_wrap && v_wrap;
      VBlankStart <= h_wrap && (DrawY == VLastVisC);
    end
  end

  assign Sync = 1'b0;

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

  // Instance A: shrunken geometry, CLK_DIV=3, so whole frames fit in a short run.
  localparam int AHV = 16, AHF = 4, AHS = 6, AHB = 4;
  localparam int AVV = 8, AVF = 2, AVS = 2, AVB = 3, ADIV = 3;
  localparam int AFRAME = (AHV + AHF + AHS + AHB) * (AVV + AVF + AVS + AVB) * ADIV;
  // Instance B: default 640x480 geometry, horizontal behaviour only.
  localparam int BHV = 640, BHF = 16, BHS = 96, BHB = 48;
  localparam int BVV = 480, BVF = 10, BVS = 2, BVB = 33, BDIV = 2;

  typedef struct packed {
    logic       pe;
    logic [9:0] x;
    logic [9:0] y;
    logic       blank;
    logic       hs;
    logic       vs;
    logic       sync;
    logic       ls;
    logic       fs;
    logic       vbs;
  } vid_t;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  int   total = 0;
  int   bad = 0;

  logic       pe_a, blank_a, hs_a, vs_a, sync_a, ls_a, fs_a, vbs_a;
  logic [9:0] x_a, y_a;
  logic       pe_b, blank_b, hs_b, vs_b, sync_b, ls_b, fs_b, vbs_b;
  logic [9:0] x_b, y_b;
  vid_t       obs_a, obs_b;
  longint     e_a, e_b;

  assign obs_a = {pe_a, x_a, y_a, blank_a, hs_a, vs_a, sync_a, ls_a, fs_a, vbs_a};
  assign obs_b = {pe_b, x_b, y_b, blank_b, hs_b, vs_b, sync_b, ls_b, fs_b, vbs_b};

  always #5 clk = ~clk;

  // Clk edges seen since reset was last released.
  always @(posedge clk or posedge rst_a) if (rst_a) e_a <= 0; else e_a <= e_a + 1;
  always @(posedge clk or posedge rst_b) if (rst_b) e_b <= 0; else e_b <= e_b + 1;

  vga_timing_gen #(
    .H_VISIBLE(AHV), .H_FRONT(AHF), .H_SYNC(AHS), .H_BACK(AHB),
    .V_VISIBLE(AVV), .V_FRONT(AVF), .V_SYNC(AVS), .V_BACK(AVB), .CLK_DIV(ADIV)
  ) dut_a (
    .Clk(clk), .Reset(rst_a), .PixelEn(pe_a), .DrawX(x_a), .DrawY(y_a), .Blank(blank_a),
    .hs(hs_a), .vs(vs_a), .Sync(sync_a), .LineStart(ls_a), .FrameStart(fs_a),
    .VBlankStart(vbs_a)
  );

  vga_timing_gen dut_b (
    .Clk(clk), .Reset(rst_b), .PixelEn(pe_b), .DrawX(x_b), .DrawY(y_b), .Blank(blank_b),
    .hs(hs_b), .vs(vs_b), .Sync(sync_b), .LineStart(ls_b), .FrameStart(fs_b),
    .VBlankStart(vbs_b)
  );

  // Reference: raster position is simply (edges / CLK_DIV) laid out line by line.
  function automatic vid_t model(longint e, int hv, int hf, int hsw, int hb,
                                 int vv, int vf, int vsw, int vb, int dv);
    vid_t   r;
    longint p;
    int     ht, vt, x, y;
    logic   newpos;
    ht = hv + hf + hsw + hb;
    vt = vv + vf + vsw + vb;
    p  = e / dv;
    x  = int'(p % ht);
    y  = int'((p / ht) % vt);
    newpos  = (e > 0) && (e % dv == 0);
    r.pe    = (e % dv) == dv - 1;
    r.x     = 10'(x);
    r.y     = 10'(y);
    r.blank = (x < hv) && (y < vv);
    r.hs    = !((x >= hv + hf) && (x < hv + hf + hsw));
    r.vs    = !((y >= vv + vf) && (y < vv + vf + vsw));
    r.sync  = 1'b0;
    r.ls    = newpos && (x == 0);
    r.fs    = newpos && (x == 0) && (y == 0);
    r.vbs   = newpos && (x == 0) && (y == vv);
    return r;
  endfunction

  function automatic vid_t model_a(longint e);
    return model(e, AHV, AHF, AHS, AHB, AVV, AVF, AVS, AVB, ADIV);
  endfunction

  function automatic vid_t model_b(longint e);
    return model(e, BHV, BHF, BHS, BHB, BVV, BVF, BVS, BVB, BDIV);
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    vid_t want;
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (5) tick();
    want = model_b(0);
    total++;
    if (obs_b !== want) begin
      bad++;
      $display("FAIL reset_held_b got=%h want=%h", obs_b, want);
    end
    want = model_a(0);
    total++;
    if (obs_a !== want) begin
      bad++;
      $display("FAIL reset_held_a got=%h want=%h", obs_a, want);
    end
    rst_a = 1'b0;
    rst_b = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) begin
      want = model_b(e_b);
      total++;
      if (obs_b !== want) begin
        bad++;
        $display("FAIL release_b e=%0d got=%h want=%h", e_b, obs_b, want);
      end
      // First PixelEn on the second Clk after release, then every other Clk.
      total++;
      if (pe_b !== ((i % 2) == 1)) begin
        bad++;
        $display("FAIL first_pixel_en i=%0d got=%b want=%b", i, pe_b, (i % 2) == 1);
      end
      tick();
    end
  endtask

  task automatic test_line();
    vid_t want;
    int   hs_low = 0;
    int   ls_cnt = 0;
    while (e_b < 3210) begin
      want = model_b(e_b);
      total++;
      if (obs_b !== want) begin
        bad++;
        $display("FAIL line_b e=%0d got=%h want=%h", e_b, obs_b, want);
      end
      if (hs_b === 1'b0) hs_low++;
      if (ls_b === 1'b1) ls_cnt++;
      tick();
    end
    total++;
    if (hs_low !== 384) begin
      bad++;
      $display("FAIL hs_low_two_lines got=%0d want=384", hs_low);
    end
    total++;
    if (ls_cnt !== 2) begin
      bad++;
      $display("FAIL line_start_count got=%0d want=2", ls_cnt);
    end
  endtask

  task automatic test_frame();
    vid_t want;
    int   vs_low = 0, fs_cnt = 0, vbs_cnt = 0, ls_cnt = 0;
    while (e_a % AFRAME != 0) begin
      want = model_a(e_a);
      total++;
      if (obs_a !== want) begin
        bad++;
        $display("FAIL align_a e=%0d got=%h want=%h", e_a, obs_a, want);
      end
      tick();
    end
    for (int i = 0; i < AFRAME; i++) begin
      want = model_a(e_a);
      total++;
      if (obs_a !== want) begin
        bad++;
        $display("FAIL frame_a e=%0d got=%h want=%h", e_a, obs_a, want);
      end
      if (vs_a === 1'b0) vs_low++;
      if (fs_a === 1'b1) fs_cnt++;
      if (vbs_a === 1'b1) vbs_cnt++;
      if (ls_a === 1'b1) ls_cnt++;
      tick();
    end
    total++;
    if (vs_low !== AVS * (AHV + AHF + AHS + AHB) * ADIV) begin
      bad++;
      $display("FAIL vs_low_frame got=%0d want=%0d", vs_low, AVS * (AHV + AHF + AHS + AHB) * ADIV);
    end
    total++;
    if ({fs_cnt, vbs_cnt} !== {32'd1, 32'd1}) begin
      bad++;
      $display("FAIL frame_pulses got fs=%0d vbs=%0d want fs=1 vbs=1", fs_cnt, vbs_cnt);
    end
    total++;
    if (ls_cnt !== AVV + AVF + AVS + AVB) begin
      bad++;
      $display("FAIL lines_per_frame got=%0d want=%0d", ls_cnt, AVV + AVF + AVS + AVB);
    end
  endtask

  task automatic test_reset_mid();
    vid_t want;
    int   run, d;
    for (int k = 0; k < 4; k++) begin
      run = $urandom_range(1, AFRAME - 1);
      for (int i = 0; i < run; i++) begin
        want = model_a(e_a);
        total++;
        if (obs_a !== want) begin
          bad++;
          $display("FAIL pre_reset_a e=%0d got=%h want=%h", e_a, obs_a, want);
        end
        tick();
      end
      // Assert reset off the clock edge, somewhere inside the pixel period.
      d = $urandom_range(1, 8);
      if (d >= 5) d++;
      #(d);
      rst_a = 1'b1;
      #1;
      want = model_a(0);
      total++;
      if (obs_a !== want) begin
        bad++;
        $display("FAIL async_reset_a k=%0d got=%h want=%h", k, obs_a, want);
      end
      @(negedge clk);
      repeat ($urandom_range(1, 4)) begin
        tick();
        total++;
        if (obs_a !== want) begin
          bad++;
          $display("FAIL reset_hold_a k=%0d got=%h want=%h", k, obs_a, want);
        end
      end
      rst_a = 1'b0;
      #1;
      run = $urandom_range(AFRAME / 4, AFRAME + 50);
      for (int i = 0; i < run; i++) begin
        want = model_a(e_a);
        total++;
        if (obs_a !== want) begin
          bad++;
          $display("FAIL restart_a e=%0d got=%h want=%h", e_a, obs_a, want);
        end
        tick();
      end
    end
  endtask

  initial begin
    test_reset();
    test_line();
    test_frame();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Raster timing generator for the 640x480 @ 60 Hz display path. It produces the pixel-rate strobe, the DrawX/DrawY coordinates, the active-video flag and the sync pulses consumed by the color mapper and the sprite/text pixel units. It also emits per-line and per-frame event pulses that the game logic uses to latch positions. The block sits between the 50 MHz system clock domain and the VGA DAC pins.

## Interface
Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- CLK_DIV, 2, Clk cycles per pixel (≥1)

Ports:
- Clk  in  1  system clock, 50 MHz; the only clock
- Reset  in  1  asynchronous, active-high reset
- PixelEn  out  1  one-Clk strobe; the raster advances on this cycle
- DrawX  out  10  current column, 0..H_TOTAL-1
- DrawY  out  10  current row, 0..V_TOTAL-1
- Blank  out  1  1 = visible pixel, 0 = blanking (color mapper drives black when 0)
- hs  out  1  horizontal sync, active-low
- vs  out  1  vertical sync, active-low
- Sync  out  1  composite sync to DAC, constant 0
- LineStart  out  1  one-Clk pulse on entry to DrawX=0
- FrameStart  out  1  one-Clk pulse on entry to (0,0)
- VBlankStart  out  1  one-Clk pulse on entry to (0,V_VISIBLE)

## Operation
- H_TOTAL = sum of H_* = 800. V_TOTAL = sum of V_* = 525. Both must be ≤1024; elaboration fails otherwise, and also fails if CLK_DIV < 1.
- Divider div counts 0..CLK_DIV-1 and wraps. PixelEn = (div == CLK_DIV-1) and is combinational from div. With CLK_DIV=1, PixelEn is constant 1 outside reset.
- On a PixelEn cycle:
  - DrawX increments.
  - At DrawX=H_TOTAL-1, DrawX wraps to 0 and DrawY increments.
  - At DrawY=V_TOTAL-1 together with DrawX wrap, DrawY wraps to 0.
- DrawX and DrawY are the counter registers themselves.
- hs, vs and Blank are registered, computed from the next counter values, so they always describe the current DrawX/DrawY with zero skew:
  - Blank = DrawX < H_VISIBLE && DrawY < V_VISIBLE
  - hs = 0 iff H_VISIBLE+H_FRONT ≤ DrawX < H_VISIBLE+H_FRONT+H_SYNC, i.e. 656..751
  - vs = 0 iff V_VISIBLE+V_FRONT ≤ DrawY < V_VISIBLE+V_FRONT+V_SYNC, i.e. 490..491
- Event pulses are registered. Each is high for exactly one Clk: the first Clk cycle in which the counters hold the new position.
  - LineStart fires every line.
  - FrameStart fires every frame wrap; it does not fire out of reset.
  - VBlankStart fires once per frame.
  - At (0,0), LineStart and FrameStart are high together.

## Timing
- Reset values: div=0, DrawX=0, DrawY=0, Blank=1, hs=1, vs=1, Sync=0, all pulses 0.
- Reset is asynchronous and takes effect mid-line or mid-frame with no partial pulses.
- After Reset deasserts, the first PixelEn occurs CLK_DIV Clk cycles later. DrawX=1 is visible on the Clk edge following that PixelEn.
- Each coordinate holds for exactly CLK_DIV Clk cycles.
- Line period = H_TOTAL·CLK_DIV Clk cycles (1600). Frame period = H_TOTAL·V_TOTAL·CLK_DIV Clk cycles (840 000).
- hs low for H_SYNC·CLK_DIV Clk cycles (192). vs low for V_SYNC·H_TOTAL·CLK_DIV Clk cycles (3200).

## Structure
- Package vga_pkg holds:
  - default timing constants and derived H_TOTAL/V_TOTAL
  - typedef coord_t = logic [9:0]
  - helper functions for sync-window decode
- The color mapper and the pixel units import coord_t from vga_pkg.
- Sub-module vga_wrap_counter holds the repeated counter logic:
  - parameters MAX and W
  - inputs Clk, Reset, En
  - outputs Count and Wrap (combinational, En && Count==MAX)
  - instantiated three times: div, horizontal and vertical (vertical En = horizontal Wrap)

## Test plan
- Reset held 5 cycles, then released → DrawX=0, DrawY=0, Blank=1, hs=vs=1; PixelEn first high at Clk cycle 2 after release, then every 2 cycles.
- Run one line → hs falls when DrawX reaches 656 and rises at 752 (192 Clk low); Blank falls at DrawX=640; at 799→0, DrawY 0→1 and LineStart pulses one Clk.
- Run to DrawY=480 → VBlankStart pulses one Clk with DrawX=0; Blank stays 0 through DrawY 480..524.
- Run to DrawY=490 → vs low for exactly 3200 Clk, rises at (0,492).
- Full frame → (799,524)→(0,0) after 840 000 Clk; FrameStart and LineStart high together; no FrameStart out of initial reset.
- Assert Reset at (300,200) mid-PixelEn period → all outputs return to reset values immediately (async); no pulse glitches; sequence restarts identically.
